// File: rtl/div_ctrl.sv
// Execute-stage front end for the iterative divider: latches operands, drives start/cancel, picks quotient/remainder.
// Latency: zero-divisor and cache-hit results one cycle after accept; divider runs one cycle after div_done_i.
// Backpressure: stall_o holds EX while a request is outstanding; flush drops it and drains the divider.
module div_ctrl #(
  parameter bit CACHE_EN     = 1'b1,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        div_valid_i,
  input  logic [1:0]  div_op_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  output logic        stall_o,
  output logic        res_valid_o,
  output logic [31:0] res_o,
  output logic        div_start_o,
  output logic        div_cancel_o,
  output logic        div_signed_o,
  output logic [31:0] div_reg1_o,
  output logic [31:0] div_reg2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_done_i
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] drain_cnt_q, drain_cnt_d;

  // Request registers: op is kept as its two meaningful bits (remainder select, signedness).
  logic          mod_q;
  logic          signed_q;
  logic [31:0]   reg1_q;
  logic [31:0]   reg2_q;
  logic [31:0]   res_q, res_d;

  logic          cache_vld_q;
  logic [31:0]   cache_a_q;
  logic [31:0]   cache_b_q;
  logic          cache_s_q;
  logic [63:0]   cache_res_q;

  logic          accept;
  logic          cache_wr;
  logic          req_signed;
  logic          cache_hit;
  logic [31:0]   cache_sel;
  logic [31:0]   div_sel;

  assign req_signed = ~div_op_i[1];
  assign cache_hit  = CACHE_EN && cache_vld_q && (cache_a_q == reg1_i) &&
                      (cache_b_q == reg2_i) && (cache_s_q == req_signed);
  assign cache_sel  = div_op_i[0] ? cache_res_q[63:32] : cache_res_q[31:0];
  assign div_sel    = mod_q ? div_result_i[63:32] : div_result_i[31:0];

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    res_d       = res_q;
    accept      = 1'b0;
    cache_wr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_valid_i && !flush_i) begin
          accept = 1'b1;
          if (reg2_i == 32'd0) begin
            res_d   = 32'd0;
            state_d = RESP;
          end else if (cache_hit) begin
            res_d   = cache_sel;
            state_d = RESP;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // A flush wins even over a same-cycle done: the result never reaches the cache.
        if (flush_i) begin
          drain_cnt_d = '0;
          state_d     = DRAIN;
        end else if (div_done_i) begin
          res_d    = div_sel;
          cache_wr = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      mod_q       <= 1'b0;
      signed_q    <= 1'b0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      res_q       <= '0;
      cache_vld_q <= 1'b0;
      cache_a_q   <= '0;
      cache_b_q   <= '0;
      cache_s_q   <= 1'b0;
      cache_res_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      res_q       <= res_d;
      if (accept) begin
        mod_q    <= div_op_i[0];
        signed_q <= req_signed;
        reg1_q   <= reg1_i;
        reg2_q   <= reg2_i;
      end
      if (cache_wr) begin
        cache_vld_q <= 1'b1;
        cache_a_q   <= reg1_q;
        cache_b_q   <= reg2_q;
        cache_s_q   <= signed_q;
        cache_res_q <= div_result_i;
      end
    end
  end

  assign res_valid_o  = (state_q == RESP) && !flush_i;
  assign res_o        = res_valid_o ? res_q : 32'd0;
  assign stall_o      = div_valid_i && !res_valid_o && !flush_i;
  assign div_start_o  = (state_q == BUSY);
  assign div_cancel_o = (state_q == DRAIN);
  assign div_signed_o = signed_q;
  assign div_reg1_o   = reg1_q;
  assign div_reg2_o   = reg2_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: instance 0 with the result cache, instance 1 without; a bench-side divider answers start.
module tb_div_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic        valid [2];
  logic [1:0]  op    [2];
  logic [31:0] reg1  [2];
  logic [31:0] reg2  [2];
  logic        stall [2];
  logic        res_valid [2];
  logic [31:0] res   [2];
  logic        start [2];
  logic        cancel[2];
  logic        sgn   [2];
  logic [31:0] dreg1 [2];
  logic [31:0] dreg2 [2];
  logic [63:0] dres  [2] = '{64'd0, 64'd0};
  logic        done  [2] = '{1'b0, 1'b0};
  int          dcnt  [2] = '{0, 0};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          lat_v [2];
  logic [31:0] cur_a [2];
  logic [31:0] cur_b [2];
  logic        cur_s [2];
  logic        active[2];
  int          sbase [2];
  int          nvalid [2] = '{0, 0};
  int          nstart [2] = '{0, 0};
  int          ncancel[2] = '{0, 0};
  int          vcyc   [2] = '{0, 0};
  logic [31:0] expq0[$];
  logic [31:0] expq1[$];

  div_ctrl #(.CACHE_EN(1'b1), .DRAIN_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush), .div_valid_i(valid[0]), .div_op_i(op[0]),
    .reg1_i(reg1[0]), .reg2_i(reg2[0]), .stall_o(stall[0]), .res_valid_o(res_valid[0]),
    .res_o(res[0]), .div_start_o(start[0]), .div_cancel_o(cancel[0]), .div_signed_o(sgn[0]),
    .div_reg1_o(dreg1[0]), .div_reg2_o(dreg2[0]), .div_result_i(dres[0]), .div_done_i(done[0])
  );

  div_ctrl #(.CACHE_EN(1'b0), .DRAIN_CYCLES(2)) u_nc (
    .clk(clk), .rst(rst), .flush_i(flush), .div_valid_i(valid[1]), .div_op_i(op[1]),
    .reg1_i(reg1[1]), .reg2_i(reg2[1]), .stall_o(stall[1]), .res_valid_o(res_valid[1]),
    .res_o(res[1]), .div_start_o(start[1]), .div_cancel_o(cancel[1]), .div_signed_o(sgn[1]),
    .div_reg1_o(dreg1[1]), .div_reg2_o(dreg2[1]), .div_result_i(dres[1]), .div_done_i(done[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plain arithmetic reference: {remainder, quotient}.
  function automatic logic [63:0] model64(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return 64'd0;
    if (s) return {32'(sa % sb), 32'(sa / sb)};
    return {a % b, a / b};
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    if (b == 32'd0) return 32'd0;
    r = model64(a, b, ~o[1]);
    return o[0] ? r[63:32] : r[31:0];
  endfunction

  always @(posedge clk) cyc++;

  // Divider stand-in: done after lat_v cycles of start, any latency the bench chooses.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst || cancel[i] || !start[i]) begin
        dcnt[i] = 0;
        done[i] = 1'b0;
      end else if (done[i]) begin
        done[i] = 1'b0;
      end else begin
        dcnt[i]++;
        if (dcnt[i] >= lat_v[i]) begin
          done[i] = 1'b1;
          dres[i] = model64(dreg1[i], dreg2[i], sgn[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin : per_inst
        logic [31:0] e;
        logic        have;
        chk("stall_rule", stall[i], valid[i] & ~flush & ~res_valid[i]);
        if (cancel[i]) ncancel[i]++;
        if (start[i]) begin
          nstart[i]++;
          chk("div_reg1", dreg1[i], cur_a[i]);
          chk("div_reg2", dreg2[i], cur_b[i]);
          chk("div_signed", sgn[i], cur_s[i]);
        end
        if (active[i] && (nstart[i] != sbase[i]) && !res_valid[i])
          chk("start_held", start[i], 1);
        if (res_valid[i]) begin
          nvalid[i]++;
          vcyc[i] = cyc;
          have = 1'b0;
          e    = 32'd0;
          if (i == 0 && expq0.size() > 0) begin e = expq0.pop_front(); have = 1'b1; end
          else if (i == 1 && expq1.size() > 0) begin e = expq1.pop_front(); have = 1'b1; end
          if (have) chk("res", res[i], e);
          else chk("unexpected_res_valid", res_valid[i], 0);
        end
      end
    end
  end

  task automatic chk_reset(input int i);
    chk("rst_stall", stall[i], 0);
    chk("rst_res_valid", res_valid[i], 0);
    chk("rst_res", res[i], 0);
    chk("rst_start", start[i], 0);
    chk("rst_cancel", cancel[i], 0);
    chk("rst_signed", sgn[i], 0);
    chk("rst_reg1", dreg1[i], 0);
    chk("rst_reg2", dreg2[i], 0);
  endtask

  task automatic set_cur(input int idx, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int lat);
    cur_a[idx] = a;
    cur_b[idx] = b;
    cur_s[idx] = ~o[1];
    lat_v[idx] = lat;
  endtask

  task automatic do_req(input int idx, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_start, input int lat);
    int n, vb;
    chk("model_pin", ref_res(o, a, b), exp_res);
    if (idx == 0) expq0.push_back(exp_res); else expq1.push_back(exp_res);
    set_cur(idx, o, a, b, lat);
    sbase[idx] = nstart[idx];
    vb = nvalid[idx];
    @(posedge clk); #1;
    valid[idx] = 1'b1; op[idx] = o; reg1[idx] = a; reg2[idx] = b; active[idx] = 1'b1;
    n = cyc;
    for (int k = 0; k < 300 && nvalid[idx] == vb; k++) begin
      @(negedge clk); #1;
    end
    chk("res_valid_timeout", nvalid[idx] - vb, 1);
    chk("start_used", nstart[idx] != sbase[idx], exp_start);
    if (exp_start) chk("slow_latency", vcyc[idx] - n, lat + 1);
    else chk("fast_latency", vcyc[idx] - n, 1);
    active[idx] = 1'b0;
    @(posedge clk); #1;
    valid[idx] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cb, vb, sb;
    rst = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0; op[i] = 2'b00; reg1[i] = 32'd0; reg2[i] = 32'd0;
      lat_v[i] = 4; cur_a[i] = 32'd0; cur_b[i] = 32'd0; cur_s[i] = 1'b0;
      active[i] = 1'b0; sbase[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    @(posedge clk); #1;
    rst = 1'b0;

    do_req(0, 2'b00, 32'd100, -32'sd7, 32'hFFFFFFF2, 1'b1, 5);
    do_req(0, 2'b01, 32'd100, -32'sd7, 32'd2, 1'b0, 5);
    do_req(0, 2'b10, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 1'b1, 7);
    do_req(0, 2'b11, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0, 7);
    do_req(0, 2'b00, 32'd5, 32'd0, 32'd0, 1'b0, 4);
    do_req(0, 2'b11, 32'd5, 32'd0, 32'd0, 1'b0, 4);
    do_req(0, 2'b00, 32'd100, 32'd7, 32'd14, 1'b1, 3);
    do_req(0, 2'b01, 32'd100, 32'd7, 32'd2, 1'b0, 3);

    // Flush alongside an IDLE request, then flush during the response cycle.
    vb = nvalid[0];
    @(posedge clk); #1;
    valid[0] = 1'b1; op[0] = 2'b00; reg1[0] = 32'd5; reg2[0] = 32'd0; flush = 1'b1;
    @(posedge clk); #1;
    valid[0] = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    valid[0] = 1'b1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    chk("flush_idle_resp_no_valid", nvalid[0] - vb, 0);

    // Flush in BUSY cycle 10.
    cb = ncancel[0]; vb = nvalid[0]; sb = nstart[0];
    set_cur(0, 2'b00, 32'd50, 32'd5, 20);
    @(posedge clk); #1;
    valid[0] = 1'b1; op[0] = 2'b00; reg1[0] = 32'd50; reg2[0] = 32'd5;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; valid[0] = 1'b0;
    repeat (6) @(posedge clk);
    chk("busy_flush_cancel_cycles", ncancel[0] - cb, 2);
    chk("busy_flush_start_cycles", nstart[0] - sb, 10);
    chk("busy_flush_no_valid", nvalid[0] - vb, 0);

    do_req(0, 2'b01, 32'd100, 32'd7, 32'd2, 1'b0, 3);
    do_req(0, 2'b00, 32'd9, 32'd3, 32'd3, 1'b1, 2);

    // Divider done in the same cycle as flush.
    cb = ncancel[0]; vb = nvalid[0];
    set_cur(0, 2'b00, 32'd77, 32'd5, 3);
    @(posedge clk); #1;
    valid[0] = 1'b1; op[0] = 2'b00; reg1[0] = 32'd77; reg2[0] = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("done_with_flush", done[0], 1);
    @(posedge clk); #1;
    flush = 1'b0; valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    chk("done_flush_cancel_cycles", ncancel[0] - cb, 2);
    chk("done_flush_no_valid", nvalid[0] - vb, 0);
    do_req(0, 2'b00, 32'd77, 32'd5, 32'd15, 1'b1, 1);

    // Reset in the middle of a divider run.
    set_cur(0, 2'b10, 32'd10, 32'd3, 20);
    @(posedge clk); #1;
    valid[0] = 1'b1; op[0] = 2'b10; reg1[0] = 32'd10; reg2[0] = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset(0);
    do_req(0, 2'b00, 32'd77, 32'd5, 32'd15, 1'b1, 4);
    do_req(0, 2'b10, 32'd10, 32'd3, 32'd3, 1'b1, 4);

    // Cache disabled: every nonzero divisor goes to the divider.
    do_req(1, 2'b00, 32'd5, 32'd0, 32'd0, 1'b0, 4);
    do_req(1, 2'b00, 32'd100, 32'd7, 32'd14, 1'b1, 4);
    do_req(1, 2'b01, 32'd100, 32'd7, 32'd2, 1'b1, 4);

    repeat (3) @(posedge clk);
    chk("pending_results_0", expq0.size(), 0);
    chk("pending_results_1", expq1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Execute-stage front end for the iterative divider; sits directly upstream of it.
- Accepts div.w / mod.w / div.wu / mod.wu requests from EX and stalls the pipeline while a request is outstanding.
- Drives the divider's start/cancel handshake, selects quotient or remainder, and handles pipeline flush.
- Short-circuits divide-by-zero and repeated operand pairs through a one-entry result cache.

Parameters:
CACHE_EN, 1, 1 enables the one-entry result cache; 0 makes every nonzero-divisor request go to the divider.
DRAIN_CYCLES, 2, cycles spent with cancel=1, start=0 after a flush before a new request may start the divider.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush_i  in  1  pipeline flush; kills the current request
div_valid_i  in  1  EX holds a divide instruction; held with operands until res_valid_o
div_op_i  in  2  00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu
reg1_i  in  32  dividend
reg2_i  in  32  divisor
stall_o  out  1  pipeline stall request
res_valid_o  out  1  one-cycle pulse, result ready
res_o  out  32  quotient or remainder
div_start_o  out  1  divider start, held until done observed
div_cancel_o  out  1  divider cancel
div_signed_o  out  1  signed operation (op[1]==0)
div_reg1_o  out  32  latched dividend
div_reg2_o  out  32  latched divisor
div_result_i  in  64  [63:32] remainder, [31:0] quotient
div_done_i  in  1  divider done

Behaviour:
- Reset: state IDLE; cache invalid; all outputs and latched operand/op registers are 0.
- States: IDLE, BUSY, RESP, DRAIN.
- Ordering of effects:
  - The IDLE accept is cycle N.
  - A registered transition written "at the end of cycle X" first affects outputs in cycle X+1.
- IDLE, on div_valid_i & ~flush_i:
  - Latch op, reg1 and reg2.
  - If reg2_i==0: stage result 0, go to RESP.
  - Else if CACHE_EN & cache valid & (reg1, reg2, signed) match: stage the selected cached half, go to RESP.
  - Else: go to BUSY.
- BUSY:
  - div_start_o=1; div_reg1_o, div_reg2_o and div_signed_o come from the latched registers and stay stable for the whole operation.
  - The divider samples operand signs at completion, so these outputs must not change mid-operation.
  - Waits on div_done_i; no fixed latency is assumed.
  - On div_done_i & ~flush_i: stage div_result_i[31:0] for ops 00/10 or div_result_i[63:32] for ops 01/11; write the full 64-bit result plus key into the cache; go to RESP.
  - div_start_o drops in RESP, which releases the divider.
- RESP:
  - res_valid_o=1 and res_o=staged value, for exactly one cycle.
  - At the end of the RESP cycle, state returns to IDLE.
  - The pipeline advances, so the next cycle presents the next instruction.
- stall_o = div_valid_i & ~res_valid_o & ~flush_i (combinational).
  - Zero-divisor and cache-hit requests stall exactly 1 cycle (cycle N).
  - res_valid_o is in cycle N+1.
- flush_i has priority in every state:
  - res_valid_o and stall_o are forced to 0 in the flush cycle.
  - In IDLE: the request is not accepted.
  - In RESP: the result is dropped; go to IDLE.
  - In BUSY, including when div_done_i is also high in that cycle: the result is discarded, the cache is not written, and the state goes to DRAIN.
- DRAIN:
  - div_start_o=0, div_cancel_o=1 for DRAIN_CYCLES cycles, then IDLE.
  - Requests are not accepted during DRAIN; stall_o follows its formula.
  - Two cycles guarantee the divider is back in its free state from any of its states.
- div_cancel_o is 0 outside DRAIN.
- The cache is written only on a completed, unflushed divider run and invalidated only by rst.
- rst in any state, including mid-BUSY, returns to the reset values at the next edge. The divider shares rst.

Test Plan:
- div.w 100/-7 -> res_o 0xFFFFFFF2 (-14); mod.w 100/-7 -> 2; div.wu 0xFFFFFFFF/2 -> 0x7FFFFFFF; mod.wu -> 1. In each case div_start_o is held until done, and stall_o is high until res_valid_o.
- div.w 5/0 and mod.wu 5/0 -> res_o 0, res_valid_o in cycle N+1, div_start_o never asserted.
- div.w 100/7 followed by mod.w 100/7 -> second request is a cache hit, res_o 2 in cycle N+1, no start. With CACHE_EN=0 the second request starts the divider.
- Flush at BUSY cycle 10 -> div_cancel_o high 2 cycles, no res_valid_o, cache unchanged. The next div.w 9/3 -> 3.
- div_done_i and flush_i in the same cycle -> no res_valid_o, DRAIN entered. Repeating the same operands misses the cache and starts the divider.
- rst asserted mid-BUSY -> next cycle all outputs 0, cache invalid. Then div.wu 10/3 -> 3.
